// File: rtl/wfifo_pkg.sv
// rtl/wfifo_pkg.sv - shared states, sizing defaults and counter width for the weight FIFO drain controller
package wfifo_pkg;

  localparam int DEF_SYS_ROW = 16;
  localparam int DEF_NUM_CH  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } drain_state_e;

  // Row counter must hold the value SYS_ROW itself (one past the last row).
  function automatic int cnt_width(input int sys_row);
    return $clog2(sys_row + 1);
  endfunction

endpackage

// File: rtl/wfifo_skew_line.sv
// rtl/wfifo_skew_line.sv - per-channel staggered write enables, lane k trails the beat by k advancing cycles
module wfifo_skew_line #(
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_i,
  input  logic              advance_i,
  input  logic              flush_i,
  output logic [NUM_CH-1:0] wen_o
);

  if (NUM_CH > 1) begin : g_pipe
    logic [NUM_CH-1:1] stage_q;
    logic [NUM_CH-1:1] stage_d;

    // Shift the beat one lane further each non-stalled cycle; flush drops everything in flight.
    always_comb begin
      stage_d = stage_q;
      if (flush_i) begin
        stage_d = '0;
      end else if (advance_i) begin
        stage_d[1] = beat_i;
        for (int k = 2; k < NUM_CH; k++) begin
          stage_d[k] = stage_q[k-1];
        end
      end
    end

    // Pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stage_q <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end

    // A held stage only writes on the cycle it advances, so each beat writes once per lane.
    assign wen_o = {stage_q & {(NUM_CH-1){advance_i}}, beat_i};
  end else begin : g_single
    assign wen_o = beat_i;
  end

endmodule

// File: rtl/wfifo_drain_ctrl.sv
// rtl/wfifo_drain_ctrl.sv - weight FIFO drain controller; optional lane skew with WFIFO_DRAIN_SKEW_EN
module wfifo_drain_ctrl
  import wfifo_pkg::*;
#(
  parameter  int SYS_ROW = DEF_SYS_ROW,
  parameter  int NUM_CH  = DEF_NUM_CH,
  localparam int CNT_W   = cnt_width(SYS_ROW)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  depth_i,
  input  logic [NUM_CH-1:0] ch_mask_i,
  input  logic              data_vld_i,
  input  logic              stall_i,
  input  logic              abort_i,
  output logic [NUM_CH-1:0] fifo_rd_en_o,
  output logic [NUM_CH-1:0] w_wen_o,
  output logic [CNT_W-1:0]  row_idx_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

`ifdef WFIFO_DRAIN_SKEW_EN
  localparam bit SKEW_EN = 1'b1;
`else
  localparam bit SKEW_EN = 1'b0;
`endif
  localparam bit USE_TAIL = SKEW_EN && (NUM_CH > 1);

  localparam int                TAIL_W    = (NUM_CH > 2) ? $clog2(NUM_CH - 1) : 1;
  localparam logic [TAIL_W-1:0] TAIL_LAST = TAIL_W'((NUM_CH > 1) ? NUM_CH - 2 : 0);
  localparam logic [TAIL_W-1:0] TAIL_ONE  = TAIL_W'(1);
  localparam logic [CNT_W-1:0]  MAX_DEPTH = CNT_W'(SYS_ROW);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  drain_state_e      state_q, state_d;
  logic [CNT_W-1:0]  depth_q, depth_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]  row_q, row_d;
  logic [CNT_W-1:0]  row_idx_q, row_idx_d;
  logic [TAIL_W-1:0] tail_q, tail_d;
  logic              err_q, err_d;

  logic beat;
  logic last_beat;
  logic req_legal;

  assign beat      = (state_q == RUN) && data_vld_i && !stall_i;
  assign last_beat = beat && (row_q == depth_q - CNT_ONE);
  assign req_legal = (depth_i != '0) && (depth_i <= MAX_DEPTH) && (|ch_mask_i);

  // Next-state logic: abort beats a final beat and any start; start outside IDLE only flags an error.
  always_comb begin
    state_d   = state_q;
    depth_d   = depth_q;
    mask_d    = mask_q;
    row_d     = row_q;
    row_idx_d = row_idx_q;
    tail_d    = tail_q;
    err_d     = 1'b0;

    if (beat) begin
      row_d     = row_q + CNT_ONE;
      row_idx_d = row_q;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (req_legal) begin
            state_d = RUN;
            depth_d = depth_i;
            mask_d  = ch_mask_i;
            row_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        err_d = start_i;
        if (abort_i) begin
          state_d = IDLE;
        end else if (last_beat) begin
          if (USE_TAIL) begin
            state_d = TAIL;
            tail_d  = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      TAIL: begin
        err_d = start_i;
        if (abort_i) begin
          state_d = IDLE;
        end else if (!stall_i) begin
          if (tail_q == TAIL_LAST) begin
            state_d = DONE;
          end else begin
            tail_d = tail_q + TAIL_ONE;
          end
        end
      end
      DONE: begin
        err_d   = start_i;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; everything returns to zero on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      depth_q   <= '0;
      mask_q    <= '0;
      row_q     <= '0;
      row_idx_q <= '0;
      tail_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      depth_q   <= depth_d;
      mask_q    <= mask_d;
      row_q     <= row_d;
      row_idx_q <= row_idx_d;
      tail_q    <= tail_d;
      err_q     <= err_d;
    end
  end

  assign fifo_rd_en_o = {NUM_CH{beat}} & mask_q;
  assign row_idx_o    = beat ? row_q : row_idx_q;
  assign busy_o       = (state_q == RUN) || (state_q == TAIL);
  assign done_o       = (state_q == DONE);
  assign err_o        = err_q;

`ifdef WFIFO_DRAIN_SKEW_EN
  logic [NUM_CH-1:0] lane_en;

  wfifo_skew_line #(
    .NUM_CH (NUM_CH)
  ) u_skew_line (
    .clk       (clk),
    .rst       (rst),
    .beat_i    (beat),
    .advance_i (!stall_i),
    .flush_i   (abort_i && busy_o),
    .wen_o     (lane_en)
  );

  assign w_wen_o = lane_en & mask_q;
`else
  assign w_wen_o = fifo_rd_en_o;
`endif

endmodule
